// File: rtl/layer2_loader_pkg.sv
// Shared constants for the pooled-map ping-pong buffer and the loader FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package layer2_loader_pkg;

  localparam int DATA_W     = 16;   // signed pixel width
  localparam int ADDR_W     = 9;    // buffer address width
  localparam int MAP_W      = 12;   // pooled map side length
  localparam int K          = 5;    // layer-2 kernel side length
  localparam int BANK1_BASE = 200;  // bank 0 sits at address 0

  // Window positions per side and the counter width that holds 0..MAP_W-1.
  localparam int OUT_N = MAP_W - K + 1;
  localparam int CNT_W = $clog2(MAP_W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/layer2_loader_window_addr_gen.sv
// Sliding-window address generator: kc (fastest), kr, oc, orow (slowest) over one map.
// Latency: address/flags are combinational from the counters; counters step on issue_i.
// Backpressure: counters hold whenever issue_i is low.
// Ports: clk_i/reset_i, issue_i step strobe, base_i bank base, addr_o read address,
//        win_last_o current pixel closes a window, map_final_o current pixel is the last of the map.
module layer2_loader_window_addr_gen
  import layer2_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              issue_i,
  input  logic [ADDR_W-1:0] base_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              win_last_o,
  output logic              map_final_o
);

  localparam logic [CNT_W-1:0] KMAX = CNT_W'(K - 1);
  localparam logic [CNT_W-1:0] OMAX = CNT_W'(MAP_W - K);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] kc_q, kc_d, kr_q, kr_d, oc_q, oc_d, orow_q, orow_d;
  logic [ADDR_W-1:0] row, col;

  // Odometer-style carry chain; after the final pixel every counter wraps to 0,
  // so the next map always starts at base+0.
  always_comb begin
    kc_d   = kc_q;
    kr_d   = kr_q;
    oc_d   = oc_q;
    orow_d = orow_q;
    if (issue_i) begin
      if (kc_q == KMAX) begin
        kc_d = '0;
        if (kr_q == KMAX) begin
          kr_d = '0;
          if (oc_q == OMAX) begin
            oc_d   = '0;
            orow_d = (orow_q == OMAX) ? '0 : orow_q + ONE;
          end else begin
            oc_d = oc_q + ONE;
          end
        end else begin
          kr_d = kr_q + ONE;
        end
      end else begin
        kc_d = kc_q + ONE;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      kc_q   <= '0;
      kr_q   <= '0;
      oc_q   <= '0;
      orow_q <= '0;
    end else begin
      kc_q   <= kc_d;
      kr_q   <= kr_d;
      oc_q   <= oc_d;
      orow_q <= orow_d;
    end
  end

  // Highest address is 343, which fits ADDR_W bits, so ADDR_W-wide math cannot wrap.
  assign row         = ADDR_W'(orow_q) + ADDR_W'(kr_q);
  assign col         = ADDR_W'(oc_q) + ADDR_W'(kc_q);
  assign addr_o      = base_i + row * ADDR_W'(MAP_W) + col;
  assign win_last_o  = (kr_q == KMAX) && (kc_q == KMAX);
  assign map_final_o = win_last_o && (oc_q == OMAX) && (orow_q == OMAX);

endmodule

// File: rtl/layer2_loader.sv
// Reads a finished 12x12 pooled map out of the ping-pong buffer as 5x5 stride-1 windows.
// Latency: one cycle from ram_ren to data_valid; first beat 2 cycles after save_finish rises.
// Backpressure: valid/ready; no read is issued while a beat is held, so ram_dout/dataout freeze.
// Ports: save_finish/flag from the writer, ram_addr/ram_ren/ram_dout to the buffer,
//        dataout/data_valid/data_ready/window_last to the conv engine, load_busy/load_finish/overrun status.
module layer2_loader
  import layer2_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              save_finish,
  input  logic              flag,
  input  logic [DATA_W-1:0] ram_dout,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_ren,
  output logic [DATA_W-1:0] dataout,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              window_last,
  output logic              load_busy,
  output logic              load_finish,
  output logic              overrun
);

  state_t            state_q, state_d;
  logic              save_finish_q;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d;
  logic              data_valid_q, data_valid_d;
  logic              window_last_q, window_last_d;
  logic              overrun_q, overrun_d;

  logic start, issue, handshake, win_last, map_final;

  assign start     = save_finish && !save_finish_q;
  assign handshake = data_valid_q && data_ready;
  assign issue     = (state_q == RUN) && (!data_valid_q || data_ready);

  layer2_loader_window_addr_gen u_addr_gen (
    .clk_i       (clk),
    .reset_i     (reset),
    .issue_i     (issue),
    .base_i      (rd_base_q),
    .addr_o      (ram_addr),
    .win_last_o  (win_last),
    .map_final_o (map_final)
  );

  always_comb begin
    state_d       = state_q;
    rd_base_d     = rd_base_q;
    data_valid_d  = data_valid_q;
    window_last_d = window_last_q;
    // A start that arrives while a map is still in flight (including the cycle
    // its last beat is accepted) is only flagged; the current map carries on.
    overrun_d     = overrun_q || (start && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          // The writer has already flipped flag, so the finished bank is the other one.
          rd_base_d = flag ? '0 : ADDR_W'(BANK1_BASE);
        end
      end
      RUN: begin
        if (issue && map_final) state_d = DRAIN;
      end
      DRAIN: begin
        if (handshake) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (issue) begin
      data_valid_d  = 1'b1;
      window_last_d = win_last;
    end else if (handshake) begin
      data_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      save_finish_q <= 1'b0;
      rd_base_q     <= '0;
      data_valid_q  <= 1'b0;
      window_last_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      save_finish_q <= save_finish;
      rd_base_q     <= rd_base_d;
      data_valid_q  <= data_valid_d;
      window_last_q <= window_last_d;
      overrun_q     <= overrun_d;
    end
  end

  assign ram_ren     = issue;
  assign dataout     = ram_dout;
  assign data_valid  = data_valid_q;
  assign window_last = window_last_q;
  assign overrun     = overrun_q;
  // The finish pulse coincides with acceptance of the last beat; busy drops in that same cycle.
  assign load_finish = (state_q == DRAIN) && handshake;
  assign load_busy   = (state_q != IDLE) && !load_finish;

endmodule

// File: tb/tb_layer2_loader.sv
module tb_layer2_loader;
  import layer2_loader_pkg::*;

  logic              clk = 1'b0;
  logic              reset, save_finish, flag, data_ready;
  logic [DATA_W-1:0] ram_dout = '0;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ren, data_valid, window_last, load_busy, load_finish, overrun;
  logic [DATA_W-1:0] dataout;

  always #5 clk = ~clk;

  layer2_loader dut (
    .clk         (clk),
    .reset       (reset),
    .save_finish (save_finish),
    .flag        (flag),
    .ram_dout    (ram_dout),
    .ram_addr    (ram_addr),
    .ram_ren     (ram_ren),
    .dataout     (dataout),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .window_last (window_last),
    .load_busy   (load_busy),
    .load_finish (load_finish),
    .overrun     (overrun)
  );

  // Synchronous buffer with read enable; output holds when not reading.
  logic [DATA_W-1:0] mem [0:511];
  always @(posedge clk) if (ram_ren) ram_dout <= mem[ram_addr];

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: beat n of a map = window n/25 (row-major over 8x8 positions),
  // pixel n%25 (row-major inside the 5x5 window).
  function automatic int exp_addr(input int base, input int n);
    int w, p;
    w = n / (K * K);
    p = n % (K * K);
    return base + ((w / OUT_N) + (p / K)) * MAP_W + (w % OUT_N) + (p % K);
  endfunction

  localparam int BEATS = OUT_N * OUT_N * K * K;

  int                exp_base = 0;
  int                issue_idx = 0, beat_idx = 0, last_cnt = 0, done_cnt = 0;
  bit                rand_mode = 0;
  logic [DATA_W-1:0] cap [25];
  logic [DATA_W-1:0] last_dout;

  // Per-cycle compare against the reference, sampled on the falling edge.
  initial begin : compare
    logic              stalled_prev;
    logic [DATA_W-1:0] prev_dout;
    logic              prev_last;
    stalled_prev = 1'b0;
    prev_dout    = '0;
    prev_last    = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        issue_idx    = 0;
        beat_idx     = 0;
        last_cnt     = 0;
        stalled_prev = 1'b0;
      end else begin
        if (stalled_prev) begin
          chk("stall_valid", 32'(data_valid), 32'd1);
          chk("stall_dout", 32'(dataout), 32'(prev_dout));
          chk("stall_last", 32'(window_last), 32'(prev_last));
        end
        if (data_valid && !data_ready) chk("stall_no_ren", 32'(ram_ren), 32'd0);
        if (ram_ren) begin
          chk("ren_addr", 32'(ram_addr), 32'(exp_addr(exp_base, issue_idx)));
          chk("ren_count", 32'(issue_idx < BEATS), 32'd1);
          chk("ren_busy", 32'(load_busy), 32'd1);
          issue_idx++;
        end
        if (data_valid && data_ready) begin
          chk("beat_dout", 32'(dataout), 32'(mem[exp_addr(exp_base, beat_idx)]));
          chk("beat_last", 32'(window_last), 32'((beat_idx % (K * K)) == (K * K - 1)));
          if (beat_idx < 25) cap[beat_idx] = dataout;
          last_dout = dataout;
          if (window_last) last_cnt++;
          beat_idx++;
        end
        if (load_finish) begin
          chk("fin_beats", 32'(beat_idx), 32'(BEATS));
          chk("fin_lasts", 32'(last_cnt), 32'd64);
          chk("fin_busy", 32'(load_busy), 32'd0);
          done_cnt++;
          issue_idx = 0;
          beat_idx  = 0;
          last_cnt  = 0;
        end
        stalled_prev = data_valid && !data_ready;
        prev_dout    = dataout;
        prev_last    = window_last;
      end
    end
  end

  // Random backpressure, active only while rand_mode is set.
  initial begin : ready_driver
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) data_ready = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic start_map(input logic f, input int hold);
    exp_base    = f ? 0 : BANK1_BASE;
    flag        = f;
    save_finish = 1'b1;
    repeat (hold) @(posedge clk);
    #1 save_finish = 1'b0;
  endtask

  task automatic wait_done(input int prev);
    int n = 0;
    while (done_cnt == prev && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("map_done", 32'(done_cnt), 32'(prev + 1));
  endtask

  task automatic wait_beat(input int target);
    int n = 0;
    while (beat_idx < target && n < 6000) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_beat", 32'(beat_idx), 32'(target));
  endtask

  task automatic fill_ramp();
    for (int i = 0; i < 512; i++) mem[i] = DATA_W'(i);
  endtask

  task automatic fill_rand();
    for (int i = 0; i < 512; i++) mem[i] = DATA_W'($urandom);
  endtask

  initial begin : stimulus
    int lit [25];
    int d;
    lit = '{0, 1, 2, 3, 4, 12, 13, 14, 15, 16, 24, 25, 26, 27, 28,
            36, 37, 38, 39, 40, 48, 49, 50, 51, 52};
    reset = 1'b1; save_finish = 1'b0; flag = 1'b0; data_ready = 1'b0;
    fill_ramp();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ren", 32'(ram_ren), 32'd0);
    chk("rst_addr", 32'(ram_addr), 32'd0);
    chk("rst_valid", 32'(data_valid), 32'd0);
    chk("rst_last", 32'(window_last), 32'd0);
    chk("rst_busy", 32'(load_busy), 32'd0);
    chk("rst_finish", 32'(load_finish), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Bank 0, ramp contents, full throughput.
    data_ready = 1'b1;
    d = done_cnt;
    exp_base = 0; flag = 1'b1; save_finish = 1'b1;
    @(posedge clk); #1;
    chk("lat_valid_c1", 32'(data_valid), 32'd0);
    chk("busy_on", 32'(load_busy), 32'd1);
    chk("first_ren", 32'(ram_ren), 32'd1);
    chk("first_addr", 32'(ram_addr), 32'd0);
    save_finish = 1'b0;
    @(posedge clk); #1;
    chk("lat_valid_c2", 32'(data_valid), 32'd1);
    repeat (1000) @(posedge clk);
    #1;
    chk("throughput", 32'(beat_idx), 32'd1000);
    wait_done(d);
    for (int i = 0; i < 25; i++) chk("first_window", 32'(cap[i]), 32'(lit[i]));
    chk("bank0_last", 32'(last_dout), 32'd143);
    chk("bank0_busy_off", 32'(load_busy), 32'd0);

    // Bank 1, ramp contents, random backpressure.
    rand_mode = 1;
    d = done_cnt;
    start_map(1'b0, 1);
    wait_done(d);
    chk("bank1_first", 32'(cap[0]), 32'd200);
    chk("bank1_second_row", 32'(cap[5]), 32'd212);
    chk("bank1_last", 32'(last_dout), 32'd343);
    rand_mode = 0;
    @(posedge clk); #1;

    // Random contents, 3-cycle stall in the middle of a window.
    fill_rand();
    data_ready = 1'b1;
    d = done_cnt;
    start_map(1'b1, 1);
    wait_beat(37);
    data_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stall_hold_ren", 32'(ram_ren), 32'd0);
      chk("stall_hold_valid", 32'(data_valid), 32'd1);
    end
    data_ready = 1'b1;
    wait_done(d);

    // save_finish held high for 10 cycles: one map only, no overrun.
    fill_rand();
    rand_mode = 1;
    d = done_cnt;
    start_map(1'b0, 10);
    wait_done(d);
    repeat (50) @(posedge clk);
    #1;
    chk("held_single_map", 32'(done_cnt), 32'(d + 1));
    chk("held_overrun", 32'(overrun), 32'd0);
    rand_mode = 0;

    // Second completion at beat 800: sticky overrun, current map unaffected.
    data_ready = 1'b1;
    d = done_cnt;
    start_map(1'b1, 1);
    wait_beat(800);
    flag = 1'b0; save_finish = 1'b1;
    @(posedge clk); #1;
    chk("overrun_set", 32'(overrun), 32'd1);
    save_finish = 1'b0;
    wait_done(d);
    repeat (5) @(posedge clk);
    #1;
    chk("overrun_sticky", 32'(overrun), 32'd1);

    // Reset at beat 500 aborts; a fresh start reads from base+0 again.
    rand_mode = 1;
    start_map(1'b0, 1);
    wait_beat(500);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("abort_ren", 32'(ram_ren), 32'd0);
    chk("abort_valid", 32'(data_valid), 32'd0);
    chk("abort_last", 32'(window_last), 32'd0);
    chk("abort_busy", 32'(load_busy), 32'd0);
    chk("abort_finish", 32'(load_finish), 32'd0);
    chk("abort_overrun", 32'(overrun), 32'd0);
    chk("abort_addr", 32'(ram_addr), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("idle_no_ren", 32'(ram_ren), 32'd0);
      chk("idle_no_valid", 32'(data_valid), 32'd0);
    end
    d = done_cnt;
    exp_base = BANK1_BASE; flag = 1'b0; save_finish = 1'b1;
    @(posedge clk); #1;
    chk("restart_ren", 32'(ram_ren), 32'd1);
    chk("restart_addr", 32'(ram_addr), 32'd200);
    save_finish = 1'b0;
    wait_done(d);
    rand_mode = 0;

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
